pll_rst_seq: RTL and testbench

Parametrised PLL and reset sequencer that succeeds the single-channel PLL reset and hold block. It drives the PLL reset with a guaranteed minimum pulse width. It waits for lock, with a timeout and automatic retry, and requires lock to be stable before releasing anything. It then releases `NUM_CH` active-low reset channels in order, spaced by a fixed hold count, and reacts to lock loss and software reset requests. It sits at the board top, on the PLL reference clock, ahead of the per-domain reset synchronizers.

---
 rtl/rst_seq_pkg.sv | 21 ++
 rtl/sync_bit.sv | 25 ++
 rtl/pll_rst_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// retry counter width and a small constant helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int RETRY_W = 8;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  // Larger of two integers, usable in constant expressions for sizing.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Generic multi-flop single-bit synchronizer with synchronous reset.
// The output is the input delayed by STAGES flops.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL and reset sequencer: pulses the PLL reset, waits for a stable lock
// (with timeout and retry), then releases NUM_CH active-low channel resets
// in index order, reacting to lock loss and software reset requests.
// Optional feature macro: PLL_RST_SEQ_LOCK_LOSS_EN -- when defined, lock
// loss while in RUN restarts the full sequence; otherwise RUN ignores lock.
module pll_rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int HOLD_CNT     = 50,
  parameter int PLL_RST_CYC  = 16,
  parameter int STABLE_CNT   = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pll_locked_i,
  input  logic               sw_rst_req_i,
  output logic               pll_rst_o,
  output logic [NUM_CH-1:0]  rst_n_o,
  output logic               done_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_o
);

  localparam int MAX_CNT = max_of(max_of(HOLD_CNT, PLL_RST_CYC),
                                  max_of(STABLE_CNT, LOCK_TIMEOUT));
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_END = CNT_W'(PLL_RST_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_END  = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  // Reject parameter sets the counters and synchronizer cannot honour.
  if (NUM_CH < 1)       begin : g_bad_num_ch  $error("NUM_CH must be >= 1");       end
  if (HOLD_CNT < 1)     begin : g_bad_hold    $error("HOLD_CNT must be >= 1");     end
  if (PLL_RST_CYC < 2)  begin : g_bad_rst_cyc $error("PLL_RST_CYC must be >= 2");  end
  if (STABLE_CNT < 1)   begin : g_bad_stable  $error("STABLE_CNT must be >= 1");   end
  if (LOCK_TIMEOUT < 1) begin : g_bad_timeout $error("LOCK_TIMEOUT must be >= 1"); end
  if (SYNC_STAGES < 2)  begin : g_bad_sync    $error("SYNC_STAGES must be >= 2");  end

  seq_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [NUM_CH-1:0]   rst_n, rst_n_nxt;
  logic                done, done_nxt;
  logic                pll_rst, pll_rst_nxt;
  logic [RETRY_W-1:0]  retry, retry_nxt;
  logic                locked;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (pll_locked_i),
    .q   (locked)
  );

  // Next-state and next-output logic; every output is computed here and
  // registered below so nothing reaches the pins combinationally.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    rst_n_nxt   = rst_n;
    done_nxt    = done;
    pll_rst_nxt = pll_rst;
    retry_nxt   = retry;

    unique case (state)
      PLL_RST: begin
        rst_n_nxt   = '0;
        done_nxt    = 1'b0;
        pll_rst_nxt = 1'b1;
        if (cnt == PLL_RST_END) begin
          state_nxt   = WAIT_LOCK;
          cnt_nxt     = '0;
          pll_rst_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      WAIT_LOCK: begin
        rst_n_nxt   = '0;
        done_nxt    = 1'b0;
        pll_rst_nxt = 1'b0;
        if (locked) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_END) begin
          state_nxt   = PLL_RST;
          cnt_nxt     = '0;
          pll_rst_nxt = 1'b1;
          if (retry != RETRY_MAX) begin
            retry_nxt = retry + RETRY_ONE;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      STABLE: begin
        rst_n_nxt   = '0;
        done_nxt    = 1'b0;
        pll_rst_nxt = 1'b0;
        if (!locked) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_END) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      RELEASE: begin
        pll_rst_nxt = 1'b0;
        if (!locked) begin
          state_nxt   = PLL_RST;
          cnt_nxt     = '0;
          idx_nxt     = '0;
          rst_n_nxt   = '0;
          done_nxt    = 1'b0;
          pll_rst_nxt = 1'b1;
        end else if (sw_rst_req_i) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          rst_n_nxt = '0;
          done_nxt  = 1'b0;
        end else if (cnt == HOLD_END) begin
          rst_n_nxt[idx] = 1'b1;
          cnt_nxt        = '0;
          if (idx == LAST_IDX) begin
            state_nxt = RUN;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_ONE;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      RUN: begin
        pll_rst_nxt = 1'b0;
        cnt_nxt     = '0;
`ifdef PLL_RST_SEQ_LOCK_LOSS_EN
        if (!locked) begin
          state_nxt   = PLL_RST;
          idx_nxt     = '0;
          rst_n_nxt   = '0;
          done_nxt    = 1'b0;
          pll_rst_nxt = 1'b1;
        end else if (sw_rst_req_i) begin
          state_nxt = RELEASE;
          idx_nxt   = '0;
          rst_n_nxt = '0;
          done_nxt  = 1'b0;
        end
`else
        if (sw_rst_req_i) begin
          state_nxt = RELEASE;
          idx_nxt   = '0;
          rst_n_nxt = '0;
          done_nxt  = 1'b0;
        end
`endif
      end

      default: begin
        state_nxt   = PLL_RST;
        cnt_nxt     = '0;
        idx_nxt     = '0;
        rst_n_nxt   = '0;
        done_nxt    = 1'b0;
        pll_rst_nxt = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces the PLL into reset
  // and holds every channel in reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= PLL_RST;
      cnt     <= '0;
      idx     <= '0;
      rst_n   <= '0;
      done    <= 1'b0;
      pll_rst <= 1'b1;
      retry   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      rst_n   <= rst_n_nxt;
      done    <= done_nxt;
      pll_rst <= pll_rst_nxt;
      retry   <= retry_nxt;
    end
  end

  assign pll_rst_o   = pll_rst;
  assign rst_n_o     = rst_n;
  assign done_o      = done;
  assign retry_cnt_o = retry;
  assign state_o     = state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Scoreboard bench for pll_rst_seq: scenarios compute expected outputs at
// absolute clock edges from the sequencing rules and queue them; a monitor
// compares the DUT against the queue head on every falling edge.
module tb_pll_rst_seq;

  localparam int NCH  = 3;
  localparam int HOLD = 4;
  localparam int PRC  = 8;
  localparam int STAB = 4;
  localparam int TMO  = 32;
  localparam int FAR  = 1 << 30;

  localparam int ST_PLL_RST = 0;
  localparam int ST_WAIT    = 1;
  localparam int ST_STABLE  = 2;
  localparam int ST_RELEASE = 3;
  localparam int ST_RUN     = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           locked = 1'b0;
  logic           sw_req = 1'b0;
  logic           pll_rst;
  logic [NCH-1:0] rst_n;
  logic           done;
  logic [7:0]     retry;
  logic [2:0]     state;

  int edge_no = 0;
  int total   = 0;
  int bad     = 0;

  int          exp_at[$];
  logic [15:0] exp_val[$];
  string       exp_name[$];

  pll_rst_seq #(
    .NUM_CH       (NCH),
    .HOLD_CNT     (HOLD),
    .PLL_RST_CYC  (PRC),
    .STABLE_CNT   (STAB),
    .LOCK_TIMEOUT (TMO),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (locked),
    .sw_rst_req_i (sw_req),
    .pll_rst_o    (pll_rst),
    .rst_n_o      (rst_n),
    .done_o       (done),
    .retry_cnt_o  (retry),
    .state_o      (state)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  function automatic logic [15:0] pack_exp(int st, int rt, bit dn, int rn, bit pr);
    logic [2:0] s3;
    logic [7:0] r8;
    logic [2:0] n3;
    s3 = 3'(st);
    r8 = 8'(rt);
    n3 = 3'(rn);
    return {s3, r8, dn, n3, pr};
  endfunction

  function automatic int sat(int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic expect_at(int at, string name, int st, int rt, bit dn, int rn, bit pr);
    exp_at.push_back(at);
    exp_val.push_back(pack_exp(st, rt, dn, rn, pr));
    exp_name.push_back(name);
  endtask

  task automatic check_output(string name, int at, logic [15:0] got, logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d got state=%0d retry=%0d done=%b rst_n=%b pll_rst=%b want state=%0d retry=%0d done=%b rst_n=%b pll_rst=%b",
               name, at, got[15:13], got[12:5], got[4], got[3:1], got[0],
               want[15:13], want[12:5], want[4], want[3:1], want[0]);
    end
  endtask

  // Monitor: compare every expectation scheduled for the edge just taken.
  always @(negedge clk) begin
    while (exp_at.size() > 0 && exp_at[0] <= edge_no) begin
      if (exp_at[0] < edge_no) begin
        total++;
        bad++;
        $display("[TB] FAIL %s missed edge=%0d now=%0d", exp_name[0], exp_at[0], edge_no);
      end else begin
        check_output(exp_name[0], edge_no, {state, retry, done, rst_n, pll_rst}, exp_val[0]);
      end
      void'(exp_at.pop_front());
      void'(exp_val.pop_front());
      void'(exp_name.pop_front());
    end
  end

  task automatic wait_edge(int e);
    while (edge_no < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while (exp_at.size() > 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_at.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain timeout pending=%0d required=0", exp_at.size());
      exp_at.delete();
      exp_val.delete();
      exp_name.delete();
    end
  endtask

  // Channel k rises HOLD edges after the previous step; only steps before limit.
  task automatic push_release(int t0, int limit);
    for (int k = 0; k < NCH; k++) begin
      int e2;
      e2 = t0 + (k + 1) * HOLD;
      if (e2 < limit) begin
        expect_at(e2 - 1, "rel_hold", ST_RELEASE, 0, 1'b0, (1 << k) - 1, 1'b0);
        expect_at(e2, "rel_step", (k == NCH - 1) ? ST_RUN : ST_RELEASE, 0,
                  (k == NCH - 1), (1 << (k + 1)) - 1, 1'b0);
      end
    end
  endtask

  // Assert reset for a random length; base is the first edge with reset low.
  task automatic apply_stimulus_reset(input bit lk, output int base);
    int s;
    rst    = 1'b1;
    locked = lk;
    sw_req = 1'b0;
    s      = edge_no;
    expect_at(s + 1, "reset_now", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    expect_at(s + 2, "reset_hold", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    wait_edge(s + 2 + int'($urandom_range(0, 3)));
    rst  = 1'b0;
    base = edge_no + 1;
  endtask

  initial begin
    int base, s, t0, a, x, len, w, w2, f, f2, r, tn;

    // Nominal bring-up with lock arriving at a random point in WAIT_LOCK.
    apply_stimulus_reset(1'b0, base);
    a  = base + int'($urandom_range(0, 25));
    s  = (base + PRC + 1 > a + 2) ? base + PRC + 1 : a + 2;
    t0 = s + STAB;
    expect_at(base + PRC - 1, "pll_rst_high", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    expect_at(base + PRC, "pll_rst_fall", ST_WAIT, 0, 1'b0, 0, 1'b0);
    expect_at(s - 1, "wait_lock", ST_WAIT, 0, 1'b0, 0, 1'b0);
    expect_at(s, "stable_entry", ST_STABLE, 0, 1'b0, 0, 1'b0);
    expect_at(s + 1, "sw_ignored_stable", ST_STABLE, 0, 1'b0, 0, 1'b0);
    expect_at(t0, "release_entry", ST_RELEASE, 0, 1'b0, 0, 1'b0);
    push_release(t0, FAR);
    wait_edge(a - 1);
    locked = 1'b1;
    wait_edge(s);
    sw_req = 1'b1;
    wait_edge(s + 1);
    sw_req = 1'b0;
    wait_drain(200);

    // Lock glitch in STABLE, then software requests in RUN and RELEASE,
    // then lock loss in RUN.
    apply_stimulus_reset(1'b1, base);
    s   = base + PRC + 1;
    x   = s + 1 + int'($urandom_range(0, STAB - 1));
    len = 1 + int'($urandom_range(0, 2));
    t0  = x + len + STAB;
    expect_at(base + PRC, "pll_rst_fall2", ST_WAIT, 0, 1'b0, 0, 1'b0);
    expect_at(s, "stable_entry2", ST_STABLE, 0, 1'b0, 0, 1'b0);
    expect_at(x - 1, "pre_glitch", ST_STABLE, 0, 1'b0, 0, 1'b0);
    expect_at(x, "glitch_wait", ST_WAIT, 0, 1'b0, 0, 1'b0);
    expect_at(x + len - 1, "glitch_hold", ST_WAIT, 0, 1'b0, 0, 1'b0);
    expect_at(x + len, "glitch_restable", ST_STABLE, 0, 1'b0, 0, 1'b0);
    expect_at(t0, "glitch_release", ST_RELEASE, 0, 1'b0, 0, 1'b0);
    push_release(t0, FAR);
    w  = t0 + NCH * HOLD + 1 + int'($urandom_range(0, 5));
    w2 = w + 1 + int'($urandom_range(0, 9));
    expect_at(w - 1, "run_before_sw", ST_RUN, 0, 1'b1, 7, 1'b0);
    expect_at(w, "sw_in_run", ST_RELEASE, 0, 1'b0, 0, 1'b0);
    push_release(w, w2);
    expect_at(w2, "sw_in_release", ST_RELEASE, 0, 1'b0, 0, 1'b0);
    push_release(w2, FAR);
    f = w2 + NCH * HOLD + 1 + int'($urandom_range(0, 5));
    expect_at(f + 1, "loss_not_yet", ST_RUN, 0, 1'b1, 7, 1'b0);
`ifdef PLL_RST_SEQ_LOCK_LOSS_EN
    expect_at(f + 2, "loss_in_run", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    expect_at(f + 2 + PRC, "loss_pll_hold", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    expect_at(f + 3 + PRC, "loss_pll_fall", ST_WAIT, 0, 1'b0, 0, 1'b0);
`else
    expect_at(f + 2, "loss_in_run_ignored", ST_RUN, 0, 1'b1, 7, 1'b0);
    expect_at(f + 12, "loss_in_run_stays", ST_RUN, 0, 1'b1, 7, 1'b0);
`endif
    wait_edge(x - 3);
    locked = 1'b0;
    wait_edge(x - 3 + len);
    locked = 1'b1;
    wait_edge(w - 1);
    sw_req = 1'b1;
    wait_edge(w);
    sw_req = 1'b0;
    wait_edge(w2 - 1);
    sw_req = 1'b1;
    wait_edge(w2);
    sw_req = 1'b0;
    wait_edge(f - 1);
    locked = 1'b0;
    wait_drain(400);

    // Lock loss in RELEASE coinciding with a software request.
    apply_stimulus_reset(1'b1, base);
    t0 = base + PRC + 1 + STAB;
    f2 = t0 + HOLD + int'($urandom_range(0, 6));
    expect_at(t0, "release_entry3", ST_RELEASE, 0, 1'b0, 0, 1'b0);
    push_release(t0, f2);
    expect_at(f2, "loss_beats_sw", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    expect_at(f2 + 1, "loss_stays_pll_rst", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    wait_edge(f2 - 3);
    locked = 1'b0;
    wait_edge(f2 - 1);
    sw_req = 1'b1;
    wait_edge(f2);
    sw_req = 1'b0;
    wait_drain(200);

    // Reset asserted mid-RELEASE, followed by a lock-timeout run.
    apply_stimulus_reset(1'b1, base);
    t0 = base + PRC + 1 + STAB;
    r  = t0 + HOLD + 1 + int'($urandom_range(0, 6));
    expect_at(t0, "release_entry4", ST_RELEASE, 0, 1'b0, 0, 1'b0);
    push_release(t0, r);
    wait_edge(r - 1);
    apply_stimulus_reset(1'b0, base);

    // Lock never arrives: PLL re-reset every PRC+1+TMO edges, retry saturates.
    expect_at(base + PRC - 1, "to_pll_high", ST_PLL_RST, 0, 1'b0, 0, 1'b1);
    expect_at(base + PRC, "to_pll_fall", ST_WAIT, 0, 1'b0, 0, 1'b0);
    for (int n = 0; n <= 256; n++) begin
      tn = base + PRC + TMO + n * (PRC + 1 + TMO);
      expect_at(tn - 1, "to_waiting", ST_WAIT, sat(n), 1'b0, 0, 1'b0);
      expect_at(tn, "to_retry", ST_PLL_RST, sat(n + 1), 1'b0, 0, 1'b1);
      expect_at(tn + PRC, "to_rst_hold", ST_PLL_RST, sat(n + 1), 1'b0, 0, 1'b1);
      expect_at(tn + PRC + 1, "to_rst_fall", ST_WAIT, sat(n + 1), 1'b0, 0, 1'b0);
    end
    wait_drain(12000);

    // Reset clears the saturated retry count.
    apply_stimulus_reset(1'b1, base);
    wait_drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
